// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch front end. Owns the program counter, runs the
//             instruction-memory read handshake and drives the write side of
//             the IF/ID pipeline register. One returned instruction can be
//             buffered to absorb a downstream stall; control-flow redirects
//             squash in-flight or buffered fetches.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             clock, all state updates on posedge
//    rst             synchronous active-high reset
//    imem_read_o     instruction-memory read request
//    imem_address_o  fetch address (word aligned)
//    imem_resp_i     one-cycle pulse, imem_rdata_i valid for current request
//    imem_rdata_i    returned instruction
//    stall_i         IF/ID must hold this cycle
//    redirect_i      taken branch/jump, squash younger fetches
//    redirect_pc_i   redirect target, bits [1:0] ignored
//    if_id_load_o    IF/ID captures pc/instr this edge
//    if_id_flush_o   IF/ID clears to zero this edge
//    if_id_pc_o      pc of delivered instruction
//    if_id_instr_o   delivered instruction
// ============================================================================
module fetch_unit #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = 'h6000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_read_o,
  output logic [WIDTH-1:0] imem_address_o,
  input  logic             imem_resp_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             if_id_load_o,
  output logic             if_id_flush_o,
  output logic [WIDTH-1:0] if_id_pc_o,
  output logic [WIDTH-1:0] if_id_instr_o
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pending_pc_q, pending_pc_d;
  logic [WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [WIDTH-1:0] hold_instr_q, hold_instr_d;

  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pc_inc;
  logic             w_unused;

  // Targets are forced word aligned; the dropped low bits are intentionally unused.
  assign w_target = {redirect_pc_i[WIDTH-1:2], 2'b00};
  assign w_pc_inc = pc_q + WIDTH'(4);
  assign w_unused = ^redirect_pc_i[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pending_pc_d   = pending_pc_q;
    hold_pc_d      = hold_pc_q;
    hold_instr_d   = hold_instr_q;

    imem_read_o    = 1'b0;
    // Address depends on registered pc only, so it stays stable for the
    // whole life of a request regardless of stall/redirect activity.
    imem_address_o = pc_q;
    if_id_load_o   = 1'b0;
    if_id_flush_o  = redirect_i;
    if_id_pc_o     = pc_q;
    if_id_instr_o  = imem_rdata_i;

    case (state_q)
      ST_FETCH: begin
        imem_read_o = 1'b1;
        if (imem_resp_i) begin
          if (redirect_i) begin
            pc_d = w_target;
          end else if (stall_i) begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata_i;
            pc_d         = w_pc_inc;
            state_d      = ST_HOLD;
          end else begin
            if_id_load_o = 1'b1;
            pc_d         = w_pc_inc;
          end
        end else if (redirect_i) begin
          // The old request is still in flight at the memory; keep its
          // address until it returns and remember where to go next.
          pending_pc_d = w_target;
          state_d      = ST_DISCARD;
        end
      end

      ST_DISCARD: begin
        imem_read_o = 1'b1;
        if (imem_resp_i) begin
          pc_d    = redirect_i ? w_target : pending_pc_q;
          state_d = ST_FETCH;
        end else if (redirect_i) begin
          pending_pc_d = w_target;
        end
      end

      ST_HOLD: begin
        if_id_pc_o    = hold_pc_q;
        if_id_instr_o = hold_instr_q;
        if (redirect_i) begin
          pc_d    = w_target;
          state_d = ST_FETCH;
        end else if (!stall_i) begin
          if_id_load_o = 1'b1;
          state_d      = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (rst) begin
      imem_read_o    = 1'b0;
      imem_address_o = RESET_PC;
      if_id_load_o   = 1'b0;
      if_id_flush_o  = 1'b0;
      if_id_pc_o     = '0;
      if_id_instr_o  = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit with a latency-configurable
//             instruction-memory model and an in-order delivery scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_read_o;
  logic [31:0] imem_address_o;
  logic        imem_resp_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        if_id_load_o;
  logic        if_id_flush_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;

  int          n_cmp  = 0;
  int          n_fail = 0;

  int          mem_lat  = 0;
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  logic [63:0] sb_q[$];

  fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h6000_0000)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_read_o    (imem_read_o),
    .imem_address_o (imem_address_o),
    .imem_resp_i    (imem_resp_i),
    .imem_rdata_i   (imem_rdata_i),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .if_id_load_o   (if_id_load_o),
    .if_id_flush_o  (if_id_flush_o),
    .if_id_pc_o     (if_id_pc_o),
    .if_id_instr_o  (if_id_instr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h6000_0000) ? 32'h0000_0013 : (a ^ 32'h5A5A_0003);
  endfunction

  // One clock cycle: drive inputs after the edge, run the memory model,
  // then return at the falling edge where outputs are sampled.
  task automatic tick(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst           = r;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    #1;
    if (r) begin
      mem_busy     = 1'b0;
      imem_resp_i  = 1'b0;
      imem_rdata_i = '0;
    end else begin
      if (imem_read_o && !mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mem_addr = imem_address_o;
      end
      if (mem_busy && mem_cnt == mem_lat) begin
        imem_resp_i  = 1'b1;
        imem_rdata_i = mem_data(mem_addr);
        mem_busy     = 1'b0;
      end else begin
        imem_resp_i  = 1'b0;
        imem_rdata_i = 32'hDEAD_BEEF;
        if (mem_busy) mem_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    sb_q.delete();
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 32'h1234_5678);
    n_cmp++;
    if (imem_read_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_read got=%b exp=0", imem_read_o);
    end
    n_cmp++;
    if (imem_address_o !== 32'h6000_0000) begin
      n_fail++; $display("FAIL reset_addr got=%h exp=60000000", imem_address_o);
    end
    n_cmp++;
    if ({if_id_load_o, if_id_flush_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_load_flush got=%b exp=00", {if_id_load_o, if_id_flush_o});
    end
    n_cmp++;
    if ({if_id_pc_o, if_id_instr_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_pc_instr got=%h exp=0", {if_id_pc_o, if_id_instr_o});
    end
  endtask

  task automatic test_l0_stream();
    logic [31:0] exp_pc;
    logic [63:0] exp;
    mem_lat = 0;
    do_reset();
    exp_pc = 32'h6000_0000;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back({exp_pc, mem_data(exp_pc)});
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (imem_address_o !== exp_pc || imem_read_o !== 1'b1) begin
        n_fail++; $display("FAIL l0_addr cyc=%0d got=%h/%b exp=%h/1", i, imem_address_o, imem_read_o, exp_pc);
      end
      n_cmp++;
      if (!if_id_load_o) begin
        n_fail++; $display("FAIL l0_load cyc=%0d got=0 exp=1", i);
      end else begin
        exp = sb_q.pop_front();
        if ({if_id_pc_o, if_id_instr_o} !== exp) begin
          n_fail++; $display("FAIL l0_data cyc=%0d got=%h exp=%h", i, {if_id_pc_o, if_id_instr_o}, exp);
        end
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall_hold();
    logic        st;
    logic [63:0] exp;
    mem_lat = 2;
    do_reset();
    sb_q.push_back({32'h6000_0000, 32'h0000_0013});
    for (int i = 0; i < 7; i++) begin
      st = (i < 5);
      tick(1'b0, st, 1'b0, 32'h0);
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (imem_read_o !== 1'b0) begin
          n_fail++; $display("FAIL hold_read cyc=%0d got=%b exp=0", i, imem_read_o);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (imem_address_o !== 32'h6000_0004 || imem_read_o !== 1'b1) begin
          n_fail++; $display("FAIL hold_next_addr got=%h/%b exp=60000004/1", imem_address_o, imem_read_o);
        end
      end
      if (if_id_load_o) begin
        n_cmp++;
        if (i != 5 || sb_q.size() == 0) begin
          n_fail++; $display("FAIL hold_load_cycle got=cyc%0d exp=cyc5", i);
        end else begin
          exp = sb_q.pop_front();
          if ({if_id_pc_o, if_id_instr_o} !== exp) begin
            n_fail++; $display("FAIL hold_data got=%h exp=%h", {if_id_pc_o, if_id_instr_o}, exp);
          end
        end
      end
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL hold_missing_load got=%0d left exp=0", sb_q.size());
    end
  endtask

  task automatic test_redirect_discard();
    logic        rd_t   [0:16];
    logic [31:0] rpc_t  [0:16];
    logic [31:0] addr_t [0:16];
    logic [63:0] exp;
    rd_t   = '{0,0,0,0,0,1,0,0,0,1,1,0,0,1,0,1,0};
    rpc_t  = '{0,0,0,0,0,32'h6000_0100,0,0,0,32'h80,32'hC0,0,0,32'h200,0,32'h307,0};
    addr_t = '{32'h6000_0000,32'h6000_0000,32'h6000_0000,32'h6000_0000,
               32'h6000_0004,32'h6000_0004,32'h6000_0004,32'h6000_0004,
               32'h6000_0100,32'h6000_0100,32'h6000_0100,32'h6000_0100,
               32'hC0,32'hC0,32'hC0,32'hC0,32'h304};
    mem_lat = 3;
    do_reset();
    sb_q.push_back({32'h6000_0000, 32'h0000_0013});
    for (int i = 0; i < 17; i++) begin
      tick(1'b0, 1'b0, rd_t[i], rpc_t[i]);
      n_cmp++;
      if (imem_address_o !== addr_t[i] || imem_read_o !== 1'b1) begin
        n_fail++; $display("FAIL redir_addr cyc=%0d got=%h/%b exp=%h/1", i, imem_address_o, imem_read_o, addr_t[i]);
      end
      n_cmp++;
      if (if_id_flush_o !== rd_t[i]) begin
        n_fail++; $display("FAIL redir_flush cyc=%0d got=%b exp=%b", i, if_id_flush_o, rd_t[i]);
      end
      if (if_id_load_o) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL redir_unexpected_load cyc=%0d got pc=%h exp=none", i, if_id_pc_o);
        end else begin
          exp = sb_q.pop_front();
          if ({if_id_pc_o, if_id_instr_o} !== exp) begin
            n_fail++; $display("FAIL redir_data cyc=%0d got=%h exp=%h", i, {if_id_pc_o, if_id_instr_o}, exp);
          end
        end
      end
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL redir_missing_load got=%0d left exp=0", sb_q.size());
    end
  endtask

  task automatic test_hold_redirect();
    logic [63:0] exp;
    mem_lat = 1;
    do_reset();
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (imem_read_o !== 1'b0) begin
      n_fail++; $display("FAIL hredir_in_hold got=%b exp=0", imem_read_o);
    end
    tick(1'b0, 1'b0, 1'b1, 32'h6000_0203);
    n_cmp++;
    if ({if_id_flush_o, if_id_load_o} !== 2'b10) begin
      n_fail++; $display("FAIL hredir_flush_load got=%b exp=10", {if_id_flush_o, if_id_load_o});
    end
    sb_q.push_back({32'h6000_0200, mem_data(32'h6000_0200)});
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (imem_address_o !== 32'h6000_0200 || imem_read_o !== 1'b1 || if_id_load_o !== 1'b0) begin
      n_fail++; $display("FAIL hredir_next_addr got=%h/%b/%b exp=60000200/1/0", imem_address_o, imem_read_o, if_id_load_o);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (!if_id_load_o || sb_q.size() == 0) begin
      n_fail++; $display("FAIL hredir_load got=%b exp=1", if_id_load_o);
    end else begin
      exp = sb_q.pop_front();
      if ({if_id_pc_o, if_id_instr_o} !== exp) begin
        n_fail++; $display("FAIL hredir_data got=%h exp=%h", {if_id_pc_o, if_id_instr_o}, exp);
      end
    end
  endtask

  task automatic test_wrap_and_midreset();
    logic [63:0] exp;
    mem_lat = 0;
    do_reset();
    tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    n_cmp++;
    if ({if_id_flush_o, if_id_load_o} !== 2'b10) begin
      n_fail++; $display("FAIL wrap_redir got=%b exp=10", {if_id_flush_o, if_id_load_o});
    end
    sb_q.push_back({32'hFFFF_FFFC, mem_data(32'hFFFF_FFFC)});
    sb_q.push_back({32'h0000_0000, mem_data(32'h0000_0000)});
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (!if_id_load_o || sb_q.size() == 0) begin
        n_fail++; $display("FAIL wrap_load cyc=%0d got=%b exp=1", i, if_id_load_o);
      end else begin
        exp = sb_q.pop_front();
        if ({if_id_pc_o, if_id_instr_o} !== exp || imem_address_o !== exp[63:32]) begin
          n_fail++; $display("FAIL wrap_data cyc=%0d got=%h addr=%h exp=%h", i, {if_id_pc_o, if_id_instr_o}, imem_address_o, exp);
        end
      end
    end
    mem_lat = 3;
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (imem_address_o !== 32'h0000_0004 || if_id_load_o !== 1'b0) begin
      n_fail++; $display("FAIL wrap_req got=%h/%b exp=00000004/0", imem_address_o, if_id_load_o);
    end
    tick(1'b1, 1'b0, 1'b1, 32'h40);
    n_cmp++;
    if ({imem_read_o, if_id_load_o, if_id_flush_o} !== 3'b000 || imem_address_o !== 32'h6000_0000) begin
      n_fail++; $display("FAIL midrst_outputs got=%b addr=%h exp=000 60000000", {imem_read_o, if_id_load_o, if_id_flush_o}, imem_address_o);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (imem_address_o !== 32'h6000_0000 || imem_read_o !== 1'b1 || if_id_load_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_restart got=%h/%b/%b exp=60000000/1/0", imem_address_o, imem_read_o, if_id_load_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    logic [63:0] exp;
    int          delivered;
    mem_lat = 1;
    do_reset();
    p = 32'h6000_0000;
    for (int i = 0; i < 40; i++) begin
      sb_q.push_back({p, mem_data(p)});
      p = p + 32'd4;
    end
    delivered = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      if (if_id_load_o) begin
        n_cmp++;
        exp = sb_q.pop_front();
        delivered++;
        if ({if_id_pc_o, if_id_instr_o} !== exp) begin
          n_fail++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, {if_id_pc_o, if_id_instr_o}, exp);
        end
      end
    end
    n_cmp++;
    if (delivered < 3) begin
      n_fail++; $display("FAIL b2b_progress got=%0d exp>=3", delivered);
    end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_l0_stream();
    test_stall_hold();
    test_redirect_discard();
    test_hold_redirect();
    test_wrap_and_midreset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
